// File: rtl/utype_exec_ctrl.sv
// utype_exec_ctrl: execute-stage controller for U-type instructions (LUI, AUIPC).
// Decodes the raw instruction, forms the U-type result and queues it in a
// 2-entry skid FIFO toward writeback. It also keeps per-op retire counters.
module utype_exec_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_rd,
    output logic [31:0]      out_result,
    output logic             out_we,
    output logic [5:0]       alu_select,
    output logic             illegal,
    output logic [CNT_W-1:0] lui_count,
    output logic [CNT_W-1:0] auipc_count
);

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [5:0] SEL_NONE  = 6'b000000;
    localparam logic [5:0] SEL_LUI   = 6'b000001;
    localparam logic [5:0] SEL_AUIPC = 6'b000010;

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    localparam logic [CNT_W-1:0] RETIRE_INC = {{(CNT_W-1){1'b0}}, 1'b1};

    // Decoded view of the incoming instruction
    logic [6:0]  dec_opcode;
    logic [4:0]  dec_rd;
    logic [31:0] dec_imm_u;
    logic        dec_is_lui;
    logic        dec_is_auipc;
    logic        dec_is_utype;
    logic [5:0]  dec_sel;
    logic [31:0] dec_result;

    // Handshake strobes
    logic accept;
    logic push;
    logic pop;

    // FIFO storage; op bit is 1 for AUIPC, 0 for LUI
    logic [4:0]  ent_rd_q     [2];
    logic [4:0]  ent_rd_d     [2];
    logic [31:0] ent_result_q [2];
    logic [31:0] ent_result_d [2];
    logic        ent_we_q     [2];
    logic        ent_we_d     [2];
    logic        ent_op_q     [2];
    logic        ent_op_d     [2];

    // FIFO control
    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;

    // Status and counters
    logic [5:0]       alu_select_q, alu_select_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] lui_count_q, lui_count_d;
    logic [CNT_W-1:0] auipc_count_q, auipc_count_d;

    // Decode opcode, destination and U-immediate; AUIPC adds PC modulo 2^32
    always_comb begin
        dec_opcode   = in_instr[6:0];
        dec_rd       = in_instr[11:7];
        dec_imm_u    = {in_instr[31:12], 12'b0};
        dec_is_lui   = (dec_opcode == OPC_LUI);
        dec_is_auipc = (dec_opcode == OPC_AUIPC);
        dec_is_utype = dec_is_lui | dec_is_auipc;
        dec_sel      = SEL_NONE;
        dec_result   = dec_imm_u;
        if (dec_is_lui) begin
            dec_sel    = SEL_LUI;
            dec_result = dec_imm_u;
        end else if (dec_is_auipc) begin
            dec_sel    = SEL_AUIPC;
            dec_result = in_pc + dec_imm_u;
        end
    end

    // in_ready depends only on registered occupancy, never on out_ready
    assign in_ready  = (count_q != CNT_FULL);
    assign out_valid = (count_q != CNT_EMPTY);
    assign accept    = in_valid & in_ready & ~flush;
    assign push      = accept & dec_is_utype;
    assign pop       = out_valid & out_ready;

    assign out_rd      = ent_rd_q[rd_ptr_q];
    assign out_result  = ent_result_q[rd_ptr_q];
    assign out_we      = ent_we_q[rd_ptr_q];
    assign alu_select  = alu_select_q;
    assign illegal     = illegal_q;
    assign lui_count   = lui_count_q;
    assign auipc_count = auipc_count_q;

    // Next-state for FIFO storage, pointers, occupancy, status and counters
    always_comb begin
        ent_rd_d      = ent_rd_q;
        ent_result_d  = ent_result_q;
        ent_we_d      = ent_we_q;
        ent_op_d      = ent_op_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        alu_select_d  = alu_select_q;
        illegal_d     = accept & ~dec_is_utype;
        lui_count_d   = lui_count_q;
        auipc_count_d = auipc_count_q;

        if (push) begin
            ent_rd_d[wr_ptr_q]     = dec_rd;
            ent_result_d[wr_ptr_q] = dec_result;
            ent_we_d[wr_ptr_q]     = (dec_rd != 5'd0);
            ent_op_d[wr_ptr_q]     = dec_is_auipc;
        end

        if (accept) begin
            alu_select_d = dec_sel;
        end

        // A pop retires even when it coincides with a flush
        if (pop) begin
            if (ent_op_q[rd_ptr_q]) begin
                auipc_count_d = auipc_count_q + RETIRE_INC;
            end else begin
                lui_count_d = lui_count_q + RETIRE_INC;
            end
        end

        if (flush) begin
            count_d  = CNT_EMPTY;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_rd_q      <= '{default: '0};
            ent_result_q  <= '{default: '0};
            ent_we_q      <= '{default: 1'b0};
            ent_op_q      <= '{default: 1'b0};
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= CNT_EMPTY;
            alu_select_q  <= SEL_NONE;
            illegal_q     <= 1'b0;
            lui_count_q   <= '0;
            auipc_count_q <= '0;
        end else begin
            ent_rd_q      <= ent_rd_d;
            ent_result_q  <= ent_result_d;
            ent_we_q      <= ent_we_d;
            ent_op_q      <= ent_op_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            alu_select_q  <= alu_select_d;
            illegal_q     <= illegal_d;
            lui_count_q   <= lui_count_d;
            auipc_count_q <= auipc_count_d;
        end
    end

endmodule

// File: tb/tb_utype_exec_ctrl.sv
// tb_utype_exec_ctrl: directed-vector bench for utype_exec_ctrl.
module tb_utype_exec_ctrl;

    localparam int CNT_W = 16;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [31:0]      in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_rd;
    logic [31:0]      out_result;
    logic             out_we;
    logic [5:0]       alu_select;
    logic             illegal;
    logic [CNT_W-1:0] lui_count;
    logic [CNT_W-1:0] auipc_count;

    int n_chk;
    int n_fail;

    utype_exec_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rd      (out_rd),
        .out_result  (out_result),
        .out_we      (out_we),
        .alu_select  (alu_select),
        .illegal     (illegal),
        .lui_count   (lui_count),
        .auipc_count (auipc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [19:0] imm, input logic [4:0] rd,
                                       input logic [6:0] opc);
        return {imm, rd, opc};
    endfunction

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_pc     = 32'd0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_we", 32'(out_we), 32'd0);
        chk("rst_alu_select", 32'(alu_select), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_lui_count", 32'(lui_count), 32'd0);
        chk("rst_auipc_count", 32'(auipc_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // LUI x5, 0x12345 at pc 0x100
        in_valid = 1'b1;
        in_instr = mk(20'h12345, 5'd5, OPC_LUI);
        in_pc    = 32'h100;
        step();
        in_valid = 1'b0;
        chk("lui_out_valid", 32'(out_valid), 32'd1);
        chk("lui_out_rd", 32'(out_rd), 32'd5);
        chk("lui_out_result", out_result, 32'h12345000);
        chk("lui_out_we", 32'(out_we), 32'd1);
        chk("lui_alu_select", 32'(alu_select), 32'h01);
        chk("lui_count_pre", 32'(lui_count), 32'd0);
        step();
        chk("lui_count_post", 32'(lui_count), 32'd1);
        chk("lui_drained", 32'(out_valid), 32'd0);

        // AUIPC x1, 0xFFFFF at pc 0x2000 wraps to 0x1000
        in_valid = 1'b1;
        in_instr = mk(20'hFFFFF, 5'd1, OPC_AUIPC);
        in_pc    = 32'h2000;
        step();
        in_valid = 1'b0;
        chk("auipc_out_rd", 32'(out_rd), 32'd1);
        chk("auipc_out_result", out_result, 32'h00001000);
        chk("auipc_alu_select", 32'(alu_select), 32'h02);
        step();
        chk("auipc_count_1", 32'(auipc_count), 32'd1);

        // Back-pressure: three back-to-back LUIs with out_ready low
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = mk(20'h00001, 5'd2, OPC_LUI);
        step();
        in_instr  = mk(20'h00002, 5'd3, OPC_LUI);
        step();
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        chk("bp_head_rd", 32'(out_rd), 32'd2);
        chk("bp_head_result", out_result, 32'h00001000);
        in_instr  = mk(20'h00003, 5'd4, OPC_LUI);
        step();
        chk("bp_stall_in_ready", 32'(in_ready), 32'd0);
        chk("bp_stable_rd", 32'(out_rd), 32'd2);
        chk("bp_stable_result", out_result, 32'h00001000);
        out_ready = 1'b1;
        step();
        chk("bp_drain1_rd", 32'(out_rd), 32'd3);
        chk("bp_drain1_result", out_result, 32'h00002000);
        chk("bp_drain1_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_third_rd", 32'(out_rd), 32'd4);
        chk("bp_third_result", out_result, 32'h00003000);
        chk("bp_third_valid", 32'(out_valid), 32'd1);
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_lui_count", 32'(lui_count), 32'd4);

        // R-type opcode: illegal pulse, no enqueue
        in_valid = 1'b1;
        in_instr = 32'h002081B3;
        step();
        in_valid = 1'b0;
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_no_valid", 32'(out_valid), 32'd0);
        chk("ill_alu_select", 32'(alu_select), 32'd0);
        chk("ill_lui_count", 32'(lui_count), 32'd4);
        chk("ill_auipc_count", 32'(auipc_count), 32'd1);
        step();
        chk("ill_pulse_end", 32'(illegal), 32'd0);

        // Flush while FULL with a pending instruction
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = mk(20'h00006, 5'd6, OPC_LUI);
        step();
        step();
        chk("fl_full", 32'(in_ready), 32'd0);
        in_instr  = mk(20'h00007, 5'd7, OPC_LUI);
        flush     = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        chk("fl_alu_hold", 32'(alu_select), 32'h01);
        step();
        chk("fl_not_enq", 32'(out_valid), 32'd0);
        chk("fl_lui_count", 32'(lui_count), 32'd4);

        // Pop coincident with flush still retires
        in_valid = 1'b1;
        in_instr = mk(20'h00008, 5'd8, OPC_LUI);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush     = 1'b0;
        chk("flpop_lui_count", 32'(lui_count), 32'd5);
        chk("flpop_out_valid", 32'(out_valid), 32'd0);

        // Stream 65534 AUIPC retires to reach 0xFFFF
        in_valid = 1'b1;
        in_instr = mk(20'h00000, 5'd9, OPC_AUIPC);
        in_pc    = 32'h0;
        for (int i = 0; i < 65534; i++) begin
            step();
        end
        in_valid = 1'b0;
        step();
        chk("wrap_pre", 32'(auipc_count), 32'h0000FFFF);

        // AUIPC to x0 wraps the counter
        in_valid = 1'b1;
        in_instr = mk(20'h00012, 5'd0, OPC_AUIPC);
        in_pc    = 32'h4;
        step();
        in_valid = 1'b0;
        chk("x0_out_valid", 32'(out_valid), 32'd1);
        chk("x0_out_we", 32'(out_we), 32'd0);
        chk("x0_out_rd", 32'(out_rd), 32'd0);
        chk("x0_out_result", out_result, 32'h00012004);
        step();
        chk("wrap_post", 32'(auipc_count), 32'd0);

        // Fill FIFO, then assert reset mid-cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = mk(20'h0000A, 5'd10, OPC_LUI);
        step();
        step();
        in_valid  = 1'b0;
        chk("ar_full", 32'(in_ready), 32'd0);
        chk("ar_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_out_rd", 32'(out_rd), 32'd0);
        chk("ar_out_result", out_result, 32'd0);
        chk("ar_out_we", 32'(out_we), 32'd0);
        chk("ar_alu_select", 32'(alu_select), 32'd0);
        chk("ar_illegal", 32'(illegal), 32'd0);
        chk("ar_lui_count", 32'(lui_count), 32'd0);
        chk("ar_auipc_count", 32'(auipc_count), 32'd0);
        chk("ar_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/utype_exec_ctrl.md
Name: utype_exec_ctrl

Overview:
- Execute-stage controller for U-type instructions (LUI, AUIPC) in the basic pipeline.
- Decodes the raw instruction and generates the 6-bit aluSelect code (000010 AUIPC, 000001 LUI) and the shifted immediate.
- Computes the U-type result and buffers it in a 2-entry skid FIFO toward writeback, with valid/ready handshakes on both sides, pipeline flush, and per-op retire counters.

Parameters:
- CNT_W, 16, width of the LUI and AUIPC retire counters (wrap-around).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream (ID/EX) holds a valid instruction
- in_ready  output  1  block can accept an instruction this cycle
- in_instr  input  32  raw instruction word
- in_pc  input  32  PC of in_instr
- flush  input  1  synchronous pipeline flush (branch mispredict/trap)
- out_valid  output  1  head FIFO entry valid toward writeback
- out_ready  input  1  writeback accepts head entry
- out_rd  output  5  destination register of head entry
- out_result  output  32  result of head entry
- out_we  output  1  register write enable of head entry (0 when rd==x0)
- alu_select  output  6  aluSelect code of the most recently accepted instruction
- illegal  output  1  one-cycle pulse: accepted opcode was not LUI/AUIPC
- lui_count  output  CNT_W  LUI instructions retired to writeback
- auipc_count  output  CNT_W  AUIPC instructions retired to writeback

Behaviour:
- Reset (rst_n low, asynchronous): FIFO emptied, count=0, wr/rd pointers=0, out_valid=0, out_rd=0, out_result=0, out_we=0, alu_select=000000, illegal=0, both counters=0.
- Decode (combinational on in_instr):
  - opcode=in_instr[6:0]; rd=in_instr[11:7]; imm_u={in_instr[31:12],12'b0}.
  - 0110111 → LUI, select 000001, result=imm_u.
  - 0010111 → AUIPC, select 000010, result=in_pc+imm_u, truncated mod 2^32 (no carry out).
  - any other opcode → select 000000.
- Accept:
  - accept = in_valid & in_ready & ~flush.
  - in_ready = (count != 2). No combinational path from out_ready to in_ready.
- On accept of LUI/AUIPC:
  - Entry {rd, result, we=(rd!=0), op} is written at wr_ptr; wr_ptr toggles.
  - alu_select registers the decoded code.
  - Latency: the entry is visible on out_* in the cycle after acceptance (1 cycle), when the FIFO was empty.
- On accept of any other opcode:
  - No FIFO write; illegal=1 for exactly the next cycle; alu_select registers 000000.
- FIFO state machine, states EMPTY(0), ONE(1), FULL(2):
  - push only → +1; pop only → −1; push+pop in ONE → stays ONE.
  - Push is impossible in FULL (in_ready=0).
  - pop = out_valid & out_ready.
  - out_valid = (count != 0); out_* reflect entry at rd_ptr and hold stable while out_valid & ~out_ready.
- Retire counters:
  - On pop, increment lui_count or auipc_count per the entry's op, including rd==x0 entries.
  - Counters wrap from 2^CNT_W−1 to 0.
- Flush:
  - In the cycle flush=1: count→0, pointers→0, out_valid→0 next cycle, illegal→0; no push.
  - A pop coincident with flush still retires and counts; counters are not cleared by flush.
  - alu_select holds its value.
- Reset mid-operation: immediate clear of all state to reset values regardless of handshake phase; no partial counter update.
- x0 destination: entry still enqueued and handshaken with out_we=0; out_result holds the computed value.

Test Plan:
- LUI x5, 0x12345 at pc=0x100, out_ready=1 → next cycle out_valid=1, out_rd=5, out_result=0x12345000, out_we=1, alu_select=000001; lui_count=1 after the pop.
- AUIPC x1, 0xFFFFF at pc=0x00002000 → out_result=0xFFFFF000+0x2000=0x00001000 (wrap), alu_select=000010.
- out_ready=0, three back-to-back LUIs → first two accepted, in_ready=0 on the third cycle, out_* stable on entry 1; release out_ready → entries drain in order, third then accepted.
- Opcode 0110011 (R-type) accepted → illegal pulses 1 cycle, no out_valid, alu_select=000000, counters unchanged.
- FIFO FULL, flush=1 with in_valid=1 → next cycle count=0, out_valid=0, in_ready=1, pending instruction not enqueued.
- Preload auipc_count to 0xFFFF (CNT_W=16) via 65535 retires, one more AUIPC to x0 → out_we=0, auipc_count=0x0000; assert rst_n=0 while FULL → all outputs return to reset values asynchronously.
